// File: rtl/fp16_pkg.sv
// Shared FP16 constants and the accumulator-sequencer state type.
package fp16_pkg;

  localparam int unsigned FP16_W = 16;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_BIAS  = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } acc_state_t;

endpackage

// File: rtl/fp16_accum_seq.sv
// Sequencer that chains a stream of FP16 products through an external,
// single-cycle registered FP16 adder and returns the neuron sum.
// Optional feature macro: FP16_ACC_BIAS_EN adds the latched bias after the
// last term; without it the bias port is ignored.
module fp16_accum_seq
  import fp16_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [FP16_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_data,
  output logic              add_en,
  output logic [FP16_W-1:0] add_a,
  output logic [FP16_W-1:0] add_b,
  input  logic [FP16_W-1:0] add_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP16_W-1:0] out_data,
  output logic              busy
);

  acc_state_t        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [FP16_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              accept;

`ifdef FP16_ACC_BIAS_EN
  logic [FP16_W-1:0] bias_q, bias_d;
`else
  // Bias port stays on the interface but has no load in this build.
  logic unused_bias;
  assign unused_bias = ^bias;
`endif

  // Running operand: zero for the first add of a job, else the fed-back sum.
  logic [FP16_W-1:0] acc_operand;
  assign acc_operand = first_q ? FP16_ZERO : add_sum;

  // State, job parameters and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      out_data_q  <= FP16_ZERO;
      out_valid_q <= 1'b0;
`ifdef FP16_ACC_BIAS_EN
      bias_q      <= FP16_ZERO;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef FP16_ACC_BIAS_EN
      bias_q      <= bias_d;
`endif
    end
  end

  // Next-state, adder control and handshake outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef FP16_ACC_BIAS_EN
    bias_d      = bias_q;
`endif
    in_ready    = 1'b0;
    accept      = 1'b0;
    add_en      = 1'b0;
    add_a       = FP16_ZERO;
    add_b       = FP16_ZERO;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          first_d = 1'b1;
`ifdef FP16_ACC_BIAS_EN
          bias_d  = bias;
`endif
          state_d = ST_ACC;
        end
      end

      ST_ACC: begin
        in_ready = (cnt_q < len_q);
        accept   = in_valid && in_ready;
        add_en   = accept;
        add_a    = acc_operand;
        add_b    = in_data;
        if (accept) begin
          cnt_d   = cnt_q + LEN_W'(1);
          first_d = 1'b0;
        end
        // Leave on the edge that takes the last term (or at once for len 0).
        if (cnt_d == len_q) begin
`ifdef FP16_ACC_BIAS_EN
          state_d = ST_BIAS;
`else
          state_d = ST_LATCH;
`endif
        end
      end

`ifdef FP16_ACC_BIAS_EN
      ST_BIAS: begin
        add_en  = 1'b1;
        add_a   = acc_operand;
        add_b   = bias_q;
        first_d = 1'b0;
        state_d = ST_LATCH;
      end
`endif

      ST_LATCH: begin
        // first_q still set means the adder was never used in this job.
        out_data_d  = first_q ? FP16_ZERO : add_sum;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
